// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC CPU.
// Holds the fetch address/data widths, the PC select (PS) encodings used by
// the controller, and the instruction-fetch FSM state type.
package cpu_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;

    // PC select encodings driven by the controller
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_ABS  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StFull
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit.
// Latches the PC value, reads the instruction word from instruction memory
// over a req/ack handshake and holds it in the instruction register until
// the decoder accepts it. Emits a one-cycle pc_inc pulse per loaded word and
// drops in-flight or held instructions on a branch/jump flush.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   pc_addr              current PC value
//   halt                 blocks the start of new fetches
//   flush                branch/jump taken at this edge
//   mem_req, mem_addr    read request to instruction memory
//   mem_ack, mem_rdata   read data return (one-cycle ack)
//   ir, ir_pc, extend    instruction, its address, branch offset
//   ir_valid, ir_ready   handshake with the decoder
//   pc_inc               controller applies PS = 01 at this edge
module instr_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              halt,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic [5:0]        extend,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              pc_inc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              pc_inc_q, pc_inc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            discard_q <= 1'b0;
            ir_q      <= '0;
            ir_pc_q   <= '0;
            pc_inc_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
            ir_q      <= ir_d;
            ir_pc_q   <= ir_pc_d;
            pc_inc_q  <= pc_inc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        ir_d      = ir_q;
        ir_pc_d   = ir_pc_q;
        pc_inc_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                // mem_ack deliberately ignored: a stale ack after reset lands here
                if (!halt) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                addr_d = pc_addr;
                // A flush here means pc_addr is about to change; re-latch it
                if (flush) begin
                    state_d = StIssue;
                end else if (halt) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_ack) begin
                    discard_d = 1'b0;
                    if (discard_q || flush) begin
                        state_d = StIssue;
                    end else begin
                        ir_d     = mem_rdata;
                        ir_pc_d  = addr_q;
                        pc_inc_d = 1'b1;
                        state_d  = StFull;
                    end
                end else if (flush) begin
                    // Keep the request up until memory answers, then drop the data
                    discard_d = 1'b1;
                end
            end
            StFull: begin
                // flush and ir_ready share the exit; flush just means "not consumed"
                if (flush || ir_ready) begin
                    state_d = halt ? StIdle : StIssue;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem_req  = (state_q == StWait);
    assign mem_addr = addr_q;
    assign ir       = ir_q;
    assign ir_pc    = ir_pc_q;
    assign extend   = {ir_q[8:6], ir_q[2:0]};
    assign ir_valid = (state_q == StFull);
    assign pc_inc   = pc_inc_q;

endmodule
